// File: rtl/ros2_ip_pkg.sv
// Shared IPv4 constants and state encoding for the ros2rapper IP TX path.
package ros2_ip_pkg;

    localparam int         IPV4_HDR_MIN_LEN = 20;
    localparam logic [3:0] IPV4_VERSION     = 4'd4;

    // Byte offsets of the fixed 20-byte IPv4 header.
    localparam logic [4:0] OFF_VER_IHL = 5'd0;
    localparam logic [4:0] OFF_TOS     = 5'd1;
    localparam logic [4:0] OFF_LEN     = 5'd2;
    localparam logic [4:0] OFF_TTL     = 5'd8;
    localparam logic [4:0] OFF_PROTO   = 5'd9;
    localparam logic [4:0] OFF_SRC     = 5'd12;
    localparam logic [4:0] OFF_DST     = 5'd16;
    localparam logic [4:0] OFF_LAST    = 5'd19;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        OPT,
        HOUT,
        PAYLOAD,
        DROP
    } state_e;

endpackage

// File: rtl/ros2_ip_tx_deframer.sv
// Pops IPv4 datagrams from a FWFT byte FIFO, presents the parsed header with valid/ready,
// then streams the payload; options are stripped and malformed datagrams are drained.
module ros2_ip_tx_deframer
    import ros2_ip_pkg::*;
#(
    parameter bit CHECK_VERSION = 1'b1,
    parameter int LEN_W         = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [7:0]  i_din_data,
    input  logic        i_din_empty_n,
    output logic        o_din_rd_en,
    output logic        o_tx_hdr_valid,
    input  logic        i_tx_hdr_ready,
    output logic [5:0]  o_tx_ip_dscp,
    output logic [1:0]  o_tx_ip_ecn,
    output logic [15:0] o_tx_ip_length,
    output logic [7:0]  o_tx_ip_ttl,
    output logic [7:0]  o_tx_ip_protocol,
    output logic [31:0] o_tx_ip_source_ip,
    output logic [31:0] o_tx_ip_dest_ip,
    output logic [7:0]  o_tx_payload_tdata,
    output logic        o_tx_payload_tvalid,
    input  logic        i_tx_payload_tready,
    output logic        o_tx_payload_tlast,
    output logic        o_drop
);

    state_e           state_q, state_d;
    logic [4:0]       byte_cnt_q, byte_cnt_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [LEN_W-1:0] plen_q, plen_d;
    logic             drop_pend_q, drop_pend_d;
    logic [15:0]      length_q, length_d;

    logic [7:0]       ver_ihl_q;
    logic [7:0]       tos_q;
    logic [15:0]      tot_len_q;
    logic [7:0]       ttl_q;
    logic [7:0]       proto_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;

    logic [3:0]       ihl_s;
    logic [3:0]       ver_s;
    logic [LEN_W-1:0] hlen_s;
    logic [LEN_W-1:0] total_len_s;
    logic [LEN_W-1:0] plen_s;
    logic [LEN_W-1:0] min_len_s;
    logic [LEN_W-1:0] drop_rem_s;
    logic             bad_fmt_s;

    logic             rd_en_s;
    logic             hdr_valid_s;
    logic             tvalid_s;
    logic             tlast_s;
    logic             drop_s;

    assign ihl_s       = ver_ihl_q[3:0];
    assign ver_s       = ver_ihl_q[7:4];
    assign hlen_s      = LEN_W'({ihl_s, 2'b00});
    assign total_len_s = LEN_W'(tot_len_q);
    assign min_len_s   = LEN_W'(IPV4_HDR_MIN_LEN);
    assign plen_s      = total_len_s - hlen_s;
    assign drop_rem_s  = (total_len_s > min_len_s) ? (total_len_s - min_len_s) : '0;
    // plen==0 is deliberately not part of this: those datagrams still drain their options first.
    assign bad_fmt_s   = (CHECK_VERSION && (ver_s != IPV4_VERSION)) ||
                         (ihl_s < 4'd5) || (total_len_s < hlen_s);

    // Next-state and handshake decode.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        remaining_d = remaining_q;
        plen_d      = plen_q;
        drop_pend_d = drop_pend_q;
        length_d    = length_q;
        rd_en_s     = 1'b0;
        hdr_valid_s = 1'b0;
        tvalid_s    = 1'b0;
        tlast_s     = 1'b0;
        drop_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_enable && i_din_empty_n) begin
                    state_d    = HDR;
                    byte_cnt_d = 5'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            HDR: begin
                rd_en_s = i_din_empty_n;
                if (i_din_empty_n) begin
                    byte_cnt_d = byte_cnt_q + 5'd1;
                    if (byte_cnt_q == OFF_LAST) begin
                        if (bad_fmt_s) begin
                            state_d     = DROP;
                            remaining_d = drop_rem_s;
                        end else if (ihl_s > 4'd5) begin
                            state_d     = OPT;
                            remaining_d = hlen_s - min_len_s;
                            plen_d      = plen_s;
                            drop_pend_d = (plen_s == '0);
                            length_d    = 16'(plen_s + min_len_s);
                        end else if (plen_s == '0) begin
                            state_d     = DROP;
                            remaining_d = '0;
                        end else begin
                            state_d     = HOUT;
                            remaining_d = plen_s;
                            length_d    = 16'(plen_s + min_len_s);
                        end
                    end else begin
                        state_d = HDR;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q;
                end
            end
            OPT: begin
                rd_en_s = i_din_empty_n;
                if (i_din_empty_n) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d     = drop_pend_q ? DROP : HOUT;
                        remaining_d = drop_pend_q ? '0 : plen_q;
                    end else begin
                        state_d = OPT;
                    end
                end else begin
                    remaining_d = remaining_q;
                end
            end
            HOUT: begin
                hdr_valid_s = 1'b1;
                if (i_tx_hdr_ready) begin
                    state_d = PAYLOAD;
                end else begin
                    state_d = HOUT;
                end
            end
            PAYLOAD: begin
                tvalid_s = i_din_empty_n;
                tlast_s  = i_din_empty_n && (remaining_q == LEN_W'(1));
                rd_en_s  = i_din_empty_n && i_tx_payload_tready;
                if (rd_en_s) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    state_d     = (remaining_q == LEN_W'(1)) ? IDLE : PAYLOAD;
                end else begin
                    remaining_d = remaining_q;
                end
            end
            DROP: begin
                if (|remaining_q) begin
                    rd_en_s = i_din_empty_n;
                    if (i_din_empty_n) begin
                        remaining_d = remaining_q - LEN_W'(1);
                    end else begin
                        remaining_d = remaining_q;
                    end
                end else begin
                    drop_s  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 5'd0;
            remaining_q <= '0;
            plen_q      <= '0;
            drop_pend_q <= 1'b0;
            length_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            remaining_q <= remaining_d;
            plen_q      <= plen_d;
            drop_pend_q <= drop_pend_d;
            length_q    <= length_d;
        end
    end

    // Header byte capture, indexed by position within the fixed header.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ver_ihl_q <= 8'd0;
            tos_q     <= 8'd0;
            tot_len_q <= 16'd0;
            ttl_q     <= 8'd0;
            proto_q   <= 8'd0;
            src_q     <= 32'd0;
            dst_q     <= 32'd0;
        end else if ((state_q == HDR) && i_din_empty_n) begin
            case (byte_cnt_q)
                OFF_VER_IHL:      ver_ihl_q         <= i_din_data;
                OFF_TOS:          tos_q             <= i_din_data;
                OFF_LEN:          tot_len_q[15:8]   <= i_din_data;
                OFF_LEN + 5'd1:   tot_len_q[7:0]    <= i_din_data;
                OFF_TTL:          ttl_q             <= i_din_data;
                OFF_PROTO:        proto_q           <= i_din_data;
                OFF_SRC:          src_q[31:24]      <= i_din_data;
                OFF_SRC + 5'd1:   src_q[23:16]      <= i_din_data;
                OFF_SRC + 5'd2:   src_q[15:8]       <= i_din_data;
                OFF_SRC + 5'd3:   src_q[7:0]        <= i_din_data;
                OFF_DST:          dst_q[31:24]      <= i_din_data;
                OFF_DST + 5'd1:   dst_q[23:16]      <= i_din_data;
                OFF_DST + 5'd2:   dst_q[15:8]       <= i_din_data;
                OFF_DST + 5'd3:   dst_q[7:0]        <= i_din_data;
                default:          ver_ihl_q         <= ver_ihl_q;
            endcase
        end else begin
            ver_ihl_q <= ver_ihl_q;
        end
    end

    assign o_din_rd_en         = rd_en_s;
    assign o_tx_hdr_valid      = hdr_valid_s;
    assign o_tx_payload_tvalid = tvalid_s;
    assign o_tx_payload_tlast  = tlast_s;
    assign o_tx_payload_tdata  = (state_q == PAYLOAD) ? i_din_data : 8'h00;
    assign o_drop              = drop_s;
    assign o_tx_ip_dscp        = tos_q[7:2];
    assign o_tx_ip_ecn         = tos_q[1:0];
    assign o_tx_ip_length      = length_q;
    assign o_tx_ip_ttl         = ttl_q;
    assign o_tx_ip_protocol    = proto_q;
    assign o_tx_ip_source_ip   = src_q;
    assign o_tx_ip_dest_ip     = dst_q;

endmodule
